// File: rtl/grid_monitor_pkg.sv
// Shared types and seven-segment glyph helpers for the grid monitor display stage.
// Glyphs are active-low, bit order gfedcba.
package grid_monitor_pkg;

  typedef enum logic [1:0] {
    VIEW_ROW = 2'd0,
    VIEW_COL = 2'd1,
    VIEW_BLK = 2'd2
  } view_mode_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [8:0] row_mask;
    logic [8:0] col_mask;
    logic [8:0] blk_mask;
  } snap_t;

  localparam logic [6:0] SEG_DIGIT [0:8] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_R    = 7'b0101111;
  localparam logic [6:0] SEG_C    = 7'b0100111;
  localparam logic [6:0] SEG_B    = 7'b0000011;

  // Values outside the 9x9 grid render as a dash.
  function automatic logic [6:0] seg_digit(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_DIGIT[0];
      4'd1:    return SEG_DIGIT[1];
      4'd2:    return SEG_DIGIT[2];
      4'd3:    return SEG_DIGIT[3];
      4'd4:    return SEG_DIGIT[4];
      4'd5:    return SEG_DIGIT[5];
      4'd6:    return SEG_DIGIT[6];
      4'd7:    return SEG_DIGIT[7];
      4'd8:    return SEG_DIGIT[8];
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [6:0] view_glyph(input view_mode_t v);
    case (v)
      VIEW_COL: return SEG_C;
      VIEW_BLK: return SEG_B;
      default:  return SEG_R;
    endcase
  endfunction

endpackage

// File: rtl/grid_monitor_key_debounce.sv
// Key conditioning: 2-flop synchronizer, stability counter and single-cycle press pulse.
// A key already held when reset releases is ignored until it has been seen released.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic [1:0]    warm;
  logic          armed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      warm  <= '0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      meta  <= key_n;
      sync  <= meta;
      warm  <= {warm[0], 1'b1};
      press <= 1'b0;
      // sync only carries a real sample once the reset value has flushed out
      if (warm[1] && sync) armed <= 1'b1;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync;
        press <= level && armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_monitor.sv
// Display stage for the grid solver: debounced snapshot/view keys, snapshot registers,
// stale detection and registered LED / seven-segment outputs.
module grid_monitor
  import grid_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_snap_n,
  input  logic       key_view_n,
  input  logic [3:0] cursor_row,
  input  logic [3:0] cursor_col,
  input  logic [8:0] row_mask,
  input  logic [8:0] col_mask,
  input  logic [8:0] blk_mask,
  input  logic       done,
  output logic [9:0] ledr,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  logic       snap_press;
  logic       view_press;
  view_mode_t view_q, view_d;
  snap_t      snap;
  logic       valid;
  logic       stale;
  logic       done_q;
  logic       load;
  logic [8:0] sel_mask;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_snap_key (
    .clock   (clock),
    .reset_n (reset_n),
    .key_n   (key_snap_n),
    .press   (snap_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_view_key (
    .clock   (clock),
    .reset_n (reset_n),
    .key_n   (key_view_n),
    .press   (view_press)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) view_q <= VIEW_ROW;
    else          view_q <= view_d;
  end

  always_comb begin
    view_d = view_q;
    if (view_press) begin
      case (view_q)
        VIEW_ROW: view_d = VIEW_COL;
        VIEW_COL: view_d = VIEW_BLK;
        default:  view_d = VIEW_ROW;
      endcase
    end
  end

  // A snap press coinciding with done rising still yields one load.
  assign load = snap_press | (done & ~done_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap   <= '0;
      valid  <= 1'b0;
      stale  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (load) begin
        snap  <= '{row: cursor_row, col: cursor_col, row_mask: row_mask,
                   col_mask: col_mask, blk_mask: blk_mask};
        valid <= 1'b1;
      end
      stale <= valid && ((cursor_row != snap.row) || (cursor_col != snap.col));
    end
  end

  always_comb begin
    sel_mask = '0;
    if (valid) begin
      case (view_q)
        VIEW_COL: sel_mask = snap.col_mask;
        VIEW_BLK: sel_mask = snap.blk_mask;
        default:  sel_mask = snap.row_mask;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ledr <= '0;
      hex2 <= SEG_R;
      hex1 <= SEG_DASH;
      hex0 <= SEG_DASH;
    end else begin
      ledr <= {stale, sel_mask};
      hex2 <= view_glyph(view_q);
      hex1 <= valid ? seg_digit(snap.row) : SEG_DASH;
      hex0 <= valid ? seg_digit(snap.col) : SEG_DASH;
    end
  end

endmodule

// File: tb/tb_grid_monitor.sv
// Directed bench for grid_monitor: each expected output change (value and cycle) is
// queued by the stimulus; a negedge monitor pops and checks on every change or probe.
module tb_grid_monitor;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GR = 7'b0101111;
  localparam logic [6:0] GC = 7'b0100111;
  localparam logic [6:0] GB = 7'b0000011;

  logic       clock;
  logic       reset_n;
  logic       key_snap_n;
  logic       key_view_n;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic [8:0] row_mask;
  logic [8:0] col_mask;
  logic [8:0] blk_mask;
  logic       done;
  logic [9:0] ledr;
  logic [6:0] hex2;
  logic [6:0] hex1;
  logic [6:0] hex0;

  grid_monitor #(.DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_snap_n (key_snap_n),
    .key_view_n (key_view_n),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .row_mask   (row_mask),
    .col_mask   (col_mask),
    .blk_mask   (blk_mask),
    .done       (done),
    .ledr       (ledr),
    .hex2       (hex2),
    .hex1       (hex1),
    .hex0       (hex0)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard state
  logic [30:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_id_q[$];
  int          next_id = 0;
  int          probe_cnt = 0;
  int          probe_seen = 0;
  bit          end_req = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [30:0] pack(input logic [9:0] l, input logic [6:0] h2,
                                       input logic [6:0] h1, input logic [6:0] h0);
    return {l, h2, h1, h0};
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic expect_at(input int c, input logic [30:0] v);
    exp_q.push_back(v);
    exp_cyc_q.push_back(c);
    exp_id_q.push_back(next_id);
    next_id++;
  endtask

  task automatic probe(input logic [30:0] v);
    expect_at(cyc, v);
    probe_cnt++;
    tick(1);
  endtask

  task automatic press_view(input logic [30:0] v);
    int c;
    c = cyc;
    key_view_n = 1'b0;
    expect_at(c + 8, v);
    tick(6);
    key_view_n = 1'b1;
    tick(10);
  endtask

  // monitor: every output change, or a probe request, consumes one expectation
  logic [30:0] cur;
  logic [30:0] last;
  logic [30:0] e_val;
  int          e_cyc;
  int          e_id;
  bit          first = 1;
  bit          end_done = 0;

  always @(negedge clock) begin
    cur = {ledr, hex2, hex1, hex0};
    if (first || cur !== last || probe_cnt != probe_seen) begin
      first = 0;
      last = cur;
      probe_seen = probe_cnt;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
      end else begin
        e_val = exp_q.pop_front();
        e_cyc = exp_cyc_q.pop_front();
        e_id  = exp_id_q.pop_front();
        if (cur !== e_val || cyc != e_cyc) begin
          bad++;
          $display("FAIL chk%0d got=%h at cyc %0d required=%h at cyc %0d",
                   e_id, cur, cyc, e_val, e_cyc);
        end
      end
    end
    if (end_req && !end_done) begin
      end_done = 1;
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL leftover_expectations got=%0d pending required=0 (next chk%0d)",
                 exp_q.size(), exp_id_q[0]);
      end
    end
  end

  int c;

  initial begin
    reset_n    = 1'b0;
    key_snap_n = 1'b1;
    key_view_n = 1'b1;
    cursor_row = 4'd0;
    cursor_col = 4'd0;
    row_mask   = 9'h000;
    col_mask   = 9'h000;
    blk_mask   = 9'h000;
    done       = 1'b0;

    // reset state, seen at the first negedge
    expect_at(1, pack(10'h000, GR, GD, GD));
    tick(3);
    reset_n = 1'b1;
    tick(5);

    // clean held snap press
    c = cyc;
    cursor_row = 4'd3;
    cursor_col = 4'd7;
    row_mask   = 9'h1A5;
    col_mask   = 9'h00F;
    blk_mask   = 9'h1F0;
    key_snap_n = 1'b0;
    expect_at(c + 8, pack(10'h1A5, GR, G3, G7));
    tick(10);
    key_snap_n = 1'b1;
    tick(10);

    // bounce shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      key_snap_n = 1'b0;
      tick(2);
      key_snap_n = 1'b1;
      tick(2);
    end
    tick(8);
    probe(pack(10'h1A5, GR, G3, G7));
    tick(4);

    // view cycling
    press_view(pack(10'h00F, GC, G3, G7));
    press_view(pack(10'h1F0, GB, G3, G7));
    press_view(pack(10'h1A5, GR, G3, G7));

    // stale flag, then done rising reloads
    c = cyc;
    cursor_col = 4'd2;
    expect_at(c + 2, pack(10'h3A5, GR, G3, G7));
    tick(6);
    c = cyc;
    done = 1'b1;
    expect_at(c + 2, pack(10'h3A5, GR, G3, G2));
    expect_at(c + 3, pack(10'h1A5, GR, G3, G2));
    tick(6);
    done = 1'b0;
    tick(4);

    // out-of-range row snapped
    c = cyc;
    cursor_row = 4'd12;
    key_snap_n = 1'b0;
    expect_at(c + 2, pack(10'h3A5, GR, G3, G2));
    expect_at(c + 8, pack(10'h3A5, GR, GD, G2));
    expect_at(c + 9, pack(10'h1A5, GR, GD, G2));
    tick(10);
    key_snap_n = 1'b1;
    tick(10);

    // simultaneous snap and view presses
    c = cyc;
    cursor_row = 4'd5;
    cursor_col = 4'd8;
    key_snap_n = 1'b0;
    key_view_n = 1'b0;
    expect_at(c + 2, pack(10'h3A5, GR, GD, G2));
    expect_at(c + 8, pack(10'h20F, GC, G5, G8));
    expect_at(c + 9, pack(10'h00F, GC, G5, G8));
    tick(8);
    key_snap_n = 1'b1;
    key_view_n = 1'b1;
    tick(12);

    // reset mid-debounce with the key held
    key_snap_n = 1'b0;
    tick(4);
    expect_at(cyc, pack(10'h000, GR, GD, GD));
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    probe(pack(10'h000, GR, GD, GD));
    key_snap_n = 1'b1;
    tick(10);

    // fresh press after release is accepted again
    c = cyc;
    key_snap_n = 1'b0;
    expect_at(c + 8, pack(10'h1A5, GR, G5, G8));
    tick(10);
    key_snap_n = 1'b1;
    tick(12);

    end_req = 1;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // unused glyph kept for completeness of the local table
  logic [6:0] g_zero;
  assign g_zero = G0;

endmodule
